// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: width defaults, ALU-op encodings,
// and the execute-handoff state encoding.
package wisc_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 3;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ILL   = 5'b11010;
  localparam logic [4:0] OP_RTYPE = 5'b11011;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use detector: a load sitting in execute whose destination is read by
// the instruction waiting in decode forces one bubble.
module id_ex_hazard #(
  parameter int RW = 3
) (
  input  logic          i_ex_valid,
  input  logic          i_ex_mem_rd,
  input  logic          i_ex_reg_we,
  input  logic [RW-1:0] i_ex_rd,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  input  logic          i_id_rs_used,
  input  logic          i_id_rt_used,
  output logic          o_hazard
);

  logic w_load;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_load   = i_ex_valid & i_ex_mem_rd & i_ex_reg_we;
  assign w_rs_hit = i_id_rs_used & (i_id_rs == i_ex_rd);
  assign w_rt_hit = i_id_rt_used & (i_id_rt == i_ex_rd);
  assign o_hazard = w_load & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with valid/ready handshake, load-use
// stall, writeback operand bypass (on entry and while held), flush, HALT
// retirement and a sticky illegal-opcode flag.
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [4:0]    id_alu_op,
  input  logic [1:0]    id_op_ext,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [DW-1:0] id_a,
  input  logic [DW-1:0] id_b,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc_inc,
  input  logic          id_reg_we,
  input  logic          id_mem_rd,
  input  logic          id_mem_wr,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [4:0]    ex_alu_op,
  output logic [1:0]    ex_op_ext,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc_inc,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_we,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          halted,
  output logic          err
);

  state_e        r_state;
  logic          r_ex_valid;
  logic          r_err;
  logic [4:0]    r_alu_op;
  logic [1:0]    r_op_ext;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_pc_inc;
  logic [RW-1:0] r_rd;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic          r_reg_we;
  logic          r_mem_rd;
  logic          r_mem_wr;

  logic w_run;
  logic w_hazard;
  logic w_xfer;
  logic w_retire;
  logic w_halt_go;
  logic w_hold;
  logic w_byp_a_in;
  logic w_byp_b_in;

  id_ex_hazard #(.RW(RW)) u_hazard (
    .i_ex_valid   (r_ex_valid),
    .i_ex_mem_rd  (r_mem_rd),
    .i_ex_reg_we  (r_reg_we),
    .i_ex_rd      (r_rd),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_rs_used (id_rs_used),
    .i_id_rt_used (id_rt_used),
    .o_hazard     (w_hazard)
  );

  assign w_run    = (r_state == ST_RUN);
  assign id_ready = w_run & ~flush & ~w_hazard & (~r_ex_valid | ex_ready);
  assign w_xfer   = id_valid & id_ready;
  assign w_retire = r_ex_valid & ex_ready;
  // Flush squashes the retiring slot too, so a flushed HALT never halts.
  assign w_halt_go = w_run & ~flush & w_retire & (r_alu_op == OP_HALT);
  assign w_hold    = w_run & ~flush & r_ex_valid & ~ex_ready;

  assign w_byp_a_in = wb_we & id_rs_used & (wb_reg == id_rs);
  assign w_byp_b_in = wb_we & id_rt_used & (wb_reg == id_rt);

  // Control: run/halt state, execute-slot occupancy, sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_ex_valid <= 1'b0;
      r_err      <= 1'b0;
    end else if (!w_run) begin
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else begin
      if (w_xfer && id_alu_op == OP_ILL) r_err <= 1'b1;
      if (w_halt_go) begin
        r_state    <= ST_HALTED;
        r_ex_valid <= 1'b0;
      end else if (w_xfer) begin
        r_ex_valid <= 1'b1;
      end else if (w_retire) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  // Payload: load on transfer with bypass, or refresh operands while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= '0;
      r_op_ext <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_pc_inc <= '0;
      r_rd     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_reg_we <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
    end else if (w_xfer) begin
      r_alu_op <= id_alu_op;
      r_op_ext <= id_op_ext;
      r_a      <= w_byp_a_in ? wb_data : id_a;
      r_b      <= w_byp_b_in ? wb_data : id_b;
      r_imm    <= id_imm;
      r_pc_inc <= id_pc_inc;
      r_rd     <= id_rd;
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_reg_we <= id_reg_we;
      r_mem_rd <= id_mem_rd;
      r_mem_wr <= id_mem_wr;
    end else if (w_hold) begin
      if (wb_we && wb_reg == r_rs) r_a <= wb_data;
      if (wb_we && wb_reg == r_rt) r_b <= wb_data;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_alu_op = r_alu_op;
  assign ex_op_ext = r_op_ext;
  assign ex_a      = r_a;
  assign ex_b      = r_b;
  assign ex_imm    = r_imm;
  assign ex_pc_inc = r_pc_inc;
  assign ex_rd     = r_rd;
  assign ex_reg_we = r_reg_we;
  assign ex_mem_rd = r_mem_rd;
  assign ex_mem_wr = r_mem_wr;
  assign halted    = ~w_run;
  assign err       = r_err;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 16, datapath/operand width.
REQ-002 SHALL have parameter RW, default 3, register-specifier width (8 GPRs, all writable).
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: id_valid  in  1  decode holds an instruction; id_ready  out  1  stage accepts it this cycle.
REQ-006 SHALL have ports: id_alu_op  in  5, id_op_ext  in  2  ALU-control fields; id_rs, id_rt, id_rd  in  RW; id_rs_used, id_rt_used  in  1.
REQ-007 SHALL have ports: id_a, id_b, id_imm, id_pc_inc  in  DW; id_reg_we, id_mem_rd, id_mem_wr  in  1.
REQ-008 SHALL have ports: flush  in  1  squash held and incoming instruction (branch/jump redirect).
REQ-009 SHALL have ports: wb_we  in  1, wb_reg  in  RW, wb_data  in  DW  writeback bus for operand bypass.
REQ-010 SHALL have ports: ex_valid  out  1, ex_ready  in  1; ex_alu_op  out 5, ex_op_ext  out 2, ex_a, ex_b, ex_imm, ex_pc_inc  out DW, ex_rd  out RW, ex_reg_we, ex_mem_rd, ex_mem_wr  out 1.
REQ-011 SHALL have ports: halted  out  1  HALT retired into execute; err  out  1  sticky illegal-opcode flag.

Function
REQ-012 Transfer SHALL occur on a rising edge where id_valid & id_ready; all ex_* payload registers load from id_* on transfer (latency 1 cycle).
REQ-013 id_ready SHALL equal state==RUN & ~flush & ~hazard & (~ex_valid | ex_ready).
REQ-014 hazard SHALL be ex_valid & ex_mem_rd & ex_reg_we & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
REQ-015 On hazard with ex_ready=1, ex_valid SHALL clear next cycle (one bubble); instruction remains in decode and transfers the cycle after.
REQ-016 Without transfer: ex_valid & ex_ready clears ex_valid; ex_valid & ~ex_ready holds all ex_* unchanged except REQ-018.
REQ-017 On transfer, if wb_we & wb_reg==id_rs & id_rs_used, ex_a SHALL load wb_data, else id_a; same rule for id_rt/ex_b.
REQ-018 While held (ex_valid & ~ex_ready), ex_a/ex_b SHALL be overwritten with wb_data when wb_we and the captured rs/rt (stored internally) match wb_reg.
REQ-019 flush SHALL clear ex_valid next edge, block transfer that cycle, and win over every other event; payload registers need not clear.
REQ-020 State machine: RUN, HALTED. RUN->HALTED on edge where ex_valid & ex_ready & ex_alu_op==5'b00000; HALTED only exits via reset.
REQ-021 In HALTED: id_ready=0, ex_valid=0, halted=1; flush has no further effect.
REQ-022 err SHALL set on transfer of id_alu_op==5'b11010 (unassigned encoding), instruction still forwarded; err stays set until reset.
REQ-023 Flushed or bubbled slots SHALL never set err or enter HALTED.

Reset
REQ-024 rst_n low SHALL immediately force state=RUN, ex_valid=0, halted=0, err=0, ex_reg_we=0, ex_mem_rd=0, ex_mem_wr=0; remaining payload resets to 0.
REQ-025 Reset mid-stall or mid-hold SHALL discard the held instruction; first transfer possible on first edge after rst_n rises.

Structure
REQ-026 ALU-op encodings (HALT 00000, NOP 00001, illegal 11010, R-type 11011), DW/RW defaults SHALL live in shared package wisc_pkg.
REQ-027 Load-use detection (REQ-014) SHALL be sub-module id_ex_hazard; rest is flat in id_ex_stage.

Verification
REQ-028 ADD (alu_op 11011, ext 00), id_a=0x0005, id_b=0x0003, ex_ready=1 -> next cycle ex_valid=1, ex_a=0x0005, ex_b=0x0003, ex_op_ext=00.
REQ-029 LD to r2 in execute, next instruction uses rs=r2 -> id_ready=0 one cycle, one bubble (ex_valid=0), then transfer.
REQ-030 ex_ready=0 holding ADD rs=r1; wb_we=1, wb_reg=1, wb_data=0xBEEF -> ex_a=0xBEEF next cycle, other fields unchanged.
REQ-031 flush=1 with id_valid=1 and ex_valid=1 -> ex_valid=0 next cycle, no transfer, err unchanged.
REQ-032 HALT accepted by execute -> halted=1, id_ready=0 forever; alu_op 11010 transferred -> err=1 until rst_n low, which clears both asynchronously.
